// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data access. Data has priority; after MAX_D_STREAK data grants while fetch
// waits, fetch is forced through. Optional watchdog (MEM_ARB_WATCHDOG_EN)
// aborts an access that never receives mem_ack, returns a safe response and
// raises a sticky err.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        stall_f,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        stall_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Reject parameter values the arbitration and watchdog cannot honour.
    if (MAX_D_STREAK < 1) begin : g_bad_streak
        $error("MAX_D_STREAK must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_r;
    logic [STREAK_W-1:0]   d_streak_r;
    logic                  discard_r;
    logic                  i_valid_r;
    logic                  starve_s;
    logic                  grant_i_s;
    logic                  grant_d_s;
    logic                  timeout_s;
    logic                  busy_s;

    assign starve_s = (d_streak_r == STREAK_MAX);
    assign busy_s   = (state_r == BUSY_I) || (state_r == BUSY_D);

    // A kill seen in the response cycle still hides the fetch completion.
    assign i_valid = i_valid_r & ~i_kill;
    assign stall_f = i_req & ~i_valid;
    assign stall_m = d_req & ~d_valid;

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            err_r;

    assign timeout_s = busy_s && (wd_cnt_r == WD_LAST);
    assign err       = err_r;

    // Count busy cycles; restart from zero whenever the port is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (!busy_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (!timeout_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Sticky error once an access is abandoned for lack of mem_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (timeout_s && !mem_ack) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Pick the requester to grant from IDLE: data first unless fetch is starved.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if (i_req && !i_kill && (!d_req || starve_s)) begin
                grant_i_s = 1'b1;
            end else if (d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Arbitration FSM with registered memory-side and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            d_streak_r <= {STREAK_W{1'b0}};
            discard_r  <= 1'b0;
            i_valid_r  <= 1'b0;
            d_valid    <= 1'b0;
            i_rdata    <= 32'h0;
            d_rdata    <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    i_valid_r <= 1'b0;
                    d_valid   <= 1'b0;
                    discard_r <= 1'b0;
                    if (grant_i_s) begin
                        state_r    <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_wdata  <= 32'h0;
                        mem_be     <= 4'hF;
                        d_streak_r <= {STREAK_W{1'b0}};
                    end else if (grant_d_s) begin
                        state_r   <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        if (i_req && !starve_s) begin
                            d_streak_r <= d_streak_r + STREAK_W'(1);
                        end else begin
                            d_streak_r <= d_streak_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (i_kill) begin
                        discard_r <= 1'b1;
                    end else begin
                        discard_r <= discard_r;
                    end
                    if (mem_ack) begin
                        state_r   <= RESP;
                        mem_req   <= 1'b0;
                        i_rdata   <= mem_rdata;
                        i_valid_r <= ~(discard_r | i_kill);
                    end else if (timeout_s) begin
                        state_r   <= RESP;
                        mem_req   <= 1'b0;
                        i_rdata   <= NOP_INSN;
                        i_valid_r <= ~(discard_r | i_kill);
                    end else begin
                        state_r <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state_r <= RESP;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                    end else if (timeout_s) begin
                        state_r <= RESP;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= 32'h0;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                    end else begin
                        state_r <= BUSY_D;
                    end
                end
                RESP: begin
                    i_valid_r <= 1'b0;
                    d_valid   <= 1'b0;
                    discard_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req   <= 1'b0;
                    i_valid_r <= 1'b0;
                    d_valid   <= 1'b0;
                    discard_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single unified memory port between the pipelined core's instruction-fetch requester (F stage) and data requester (M stage). Data accesses have priority, with a bounded-starvation rule for fetch. The block drives per-requester stall signals consumed by the hazard logic, and supports killing an in-flight fetch on a pipeline flush. It sits between the pipeline datapath and the memory model/bus adapter.

## Interface
- MAX_D_STREAK, 4: consecutive data grants allowed while fetch is waiting; must be ≥1.
- TIMEOUT, 255: watchdog limit in cycles (used only with the watchdog macro); must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_valid
- i_addr  in  32  fetch address
- i_kill  in  1  flush; discards the current or pending fetch response
- i_rdata  out  32  fetched word (registered)
- i_valid  out  1  1-cycle fetch completion pulse
- stall_f  out  1  i_req & ~i_valid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_valid
- d_we  in  1  write enable
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_be  in  4  byte enables
- d_rdata  out  32  load data (registered)
- d_valid  out  1  1-cycle data completion pulse
- stall_m  out  1  d_req & ~d_valid
- mem_req  out  1  memory request (registered)
- mem_we  out  1  write enable
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables (4'hF for fetch)
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  1-cycle completion
- err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE → BUSY_D when d_req, unless fetch is selected by the starvation rule.
- IDLE → BUSY_I when i_req & ~i_kill, and either no d_req or the starvation rule applies.
- IDLE holds when there is no request.
- Starvation rule: counter d_streak increments on each data grant made while i_req is high. When d_streak == MAX_D_STREAK and both requests are pending, fetch is granted and d_streak clears. d_streak also clears on any fetch grant. It saturates at MAX_D_STREAK.
- On entering BUSY_x, mem_req=1 and the mem_* fields are registered from the granted requester. They stay stable until mem_ack.
- BUSY_x with mem_ack → RESP.
  - mem_rdata is captured into i_rdata or d_rdata.
  - mem_req drops at the same edge.
- RESP: pulse i_valid or d_valid for the served requester, then go to IDLE.
  - Writes also pulse d_valid; d_rdata is unchanged on writes.
- Kill behaviour:
  - i_kill while in BUSY_I sets a discard flag. The access still completes on the memory side, but i_valid is suppressed in RESP.
  - i_kill in RESP for a fetch suppresses that i_valid.
  - The discard flag clears on entering IDLE.
- mem_ack while mem_req is low is ignored.
- In IDLE/RESP, requests are only sampled in IDLE. A requester may present a new request in the cycle after its valid pulse.

## Timing
- Reset values: mem_req/mem_we=0; mem_addr/mem_wdata=0; mem_be=0; i_valid/d_valid=0; i_rdata/d_rdata=0; err=0; state=IDLE; d_streak=0; discard=0.
- Request high in IDLE at cycle 0 → mem_req high from cycle 1.
- mem_ack at cycle k → *_valid at cycle k+1 → IDLE at k+2.
- Zero-wait memory (ack at cycle 1) gives 3 cycles per access.
- Reset mid-access: mem_req drops at the next edge; the in-flight response is discarded and no valid pulse is produced.
- Simultaneous d_req and i_req in IDLE: data wins unless the starvation rule applies.

## Configuration
- MEM_ARB_WATCHDOG_EN defined:
  - A counter runs while in BUSY_x.
  - If TIMEOUT cycles elapse without mem_ack, mem_req drops and the FSM goes to RESP.
  - The requester gets a valid pulse with rdata=32'h0 (loads) or the 32'h00000013 NOP encoding (fetch).
  - err sets and stays set until rst.
- MEM_ARB_WATCHDOG_EN undefined: the FSM waits indefinitely for mem_ack; err is tied to 0 and no counter is built.

## Test plan
- Fetch only, i_addr=0x100, ack after 2 cycles with rdata=0x00500093 → mem_req cycles 1–2, i_valid at cycle 3 with i_rdata=0x00500093, stall_f high cycles 0–2.
- d_req (store, addr 0x200, wdata 0xDEADBEEF, be 4'b0011) and i_req together → data served first with mem_we=1, mem_be=4'b0011; fetch served afterwards.
- d_req held continuously with i_req pending, MAX_D_STREAK=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- i_kill pulsed in BUSY_I → memory access still completes, no i_valid, next fetch from a new i_addr is served normally.
- rst asserted in BUSY_D → mem_req=0 next cycle, no d_valid, all outputs at reset values.
- With MEM_ARB_WATCHDOG_EN and TIMEOUT=8, mem_ack never asserted on a load → d_valid at the 9th busy cycle with d_rdata=0, err=1 and sticky.
